dpbram_sc_ext: RTL
==================

# dpbram_sc_ext

Parametrised successor to the single-clock dual-port block RAM used by the waveform path. It adds per-byte write enables, a selectable read latency with per-port read-valid strobes, a deterministic cross-port write-collision policy, and an internal memory-clear engine. It sits between the PS-side waveform loader (S port) and the waveform playback engine (M port). Both ports keep the existing S_DPBRAM_PORT / M_DPBRAM_PORT bus grouping.

## Interface
- DWIDTH, 32, data width in bits; must be a multiple of 8.
- RAM_DEPTH, 100000, words; address width AW = $clog2(RAM_DEPTH).
- READ_LATENCY, 1, 1 or 2 cycles; 2 adds an output register.
- CLEAR_VALUE, 0, DWIDTH-bit word written by the clear engine.
- CLEAR_ON_RESET, 1, if 1 the clear engine starts automatically after reset.
- Clock and reset: one clock; reset is synchronous and active-high.
  - i_clk  in  1  clock for the whole block.
  - i_rst  in  1  synchronous active-high reset.
- S port (loader side):
  - s_addr  in  AW  S port address.
  - s_ce  in  1  S port enable.
  - s_we  in  DWIDTH/8  S port byte write enables.
  - s_din  in  DWIDTH  S port write data.
  - s_dout  out  DWIDTH  S port read data.
  - s_rvalid  out  1  S read data valid, one-cycle pulse.
- M port (playback side):
  - m_addr, m_ce, m_we, m_din, m_dout, m_rvalid  same widths and meanings as the S port.
- Control and status:
  - i_clear  in  1  pulse; starts a clear sweep.
  - o_busy  out  1  high while the clear engine runs.
  - o_collision  out  1  one-cycle pulse on a same-address dual write.

## Operation
- Access type per port and cycle:
  - ce && we==0: read.
  - ce && we!=0: write of the selected bytes only; unselected bytes keep their value.
  - A write cycle does not update dout and does not pulse rvalid (no-change).
- Read-during-write across ports (one port writes address A, the other reads A in the same cycle): the read returns the old data (read-first).
- Both ports write the same address in the same cycle:
  - S byte lanes win.
  - M writes only the lanes that S does not enable.
  - o_collision pulses the next cycle.
- Out-of-range address (addr >= RAM_DEPTH):
  - Write is suppressed.
  - Read returns 0 with rvalid still asserted.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on i_clear, or on the first cycle after reset when CLEAR_ON_RESET=1.
  - In CLEAR, the S port writes CLEAR_VALUE to word k while the M port writes word k+1, k = 0, 2, 4, ...
  - CLEAR -> IDLE after the write covering word RAM_DEPTH-1, i.e. after ceil(RAM_DEPTH/2) cycles.
  - While o_busy=1, all user ce/we inputs are ignored, no rvalid pulses, and i_clear is ignored.
- Reset:
  - dout=0, rvalid=0, o_busy=0, o_collision=0; pipeline registers are cleared.
  - Memory contents are not reset.
  - Reset during CLEAR aborts the sweep; with CLEAR_ON_RESET=1 it restarts from word 0.

## Timing
- READ_LATENCY=1: read issued at cycle t -> dout valid and rvalid=1 at t+1.
- READ_LATENCY=2: read issued at cycle t -> dout valid and rvalid=1 at t+2.
- dout holds its last read value until the next read completes.
- Back-to-back reads give one result per cycle, no bubbles.
- Write data is visible to a read issued on the next cycle from either port.
- o_busy:
  - rises the cycle after i_clear, or the cycle after reset deasserts;
  - falls the cycle after the last clear write;
  - the first user access is accepted in the cycle o_busy is low.

## Structure
- Shared package dpbram_pkg holds:
  - state enum CLR_IDLE / CLR_RUN;
  - function addr_width(depth);
  - READ_LATENCY legality check constant.
- One sub-module, dpbram_port_pipe: per-port output register, latency pipeline and rvalid shift register. Instantiate it twice.
- The RAM array with RAM_STYLE="BLOCK", the byte-enable write loops, the collision masking and the clear FSM stay in the top module.

## Test plan
- Reset with CLEAR_ON_RESET=1, RAM_DEPTH=16 -> o_busy high for 8 cycles; afterwards every address reads CLEAR_VALUE; s_dout=0 during reset.
- S writes 0xAABBCCDD to addr 3 with we=4'b1111, then we=4'b0101 with 0x11223344 -> M reads 0xAA22CC44 with m_rvalid at t+READ_LATENCY.
- Same-cycle S write 0x11111111 and M write 0x22222222 to addr 5, S we=4'b0011, M we=4'b1111 -> addr 5 = 0x22221111; o_collision pulses once.
- S writes 0xDEADBEEF to addr 7 while M reads addr 7 in the same cycle -> m_dout = old value; M read next cycle returns 0xDEADBEEF.
- Pulse i_clear, then assert i_rst at sweep cycle 3 -> the sweep restarts from word 0; user writes during o_busy are dropped.
- RAM_DEPTH=100000, READ_LATENCY=2: read addr 100001 -> dout=0 with rvalid at t+2; a write to that address leaves memory unchanged.

Source files
------------

// File: rtl/dpbram_pkg.sv
// Shared types and elaboration helpers for the single-clock dual-port block RAM.
package dpbram_pkg;

    // Clear engine states
    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

    // Supported read latencies: 1 = registered array read, 2 = extra output register
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit read_latency_legal(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/dpbram_port_pipe.sv
// Per-port read output path: output register, optional second stage and the
// matching read-valid shift register. dout only changes when a read completes.
module dpbram_port_pipe #(
    parameter int DWIDTH       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_i,
    input  logic [DWIDTH-1:0] rdata_i,
    output logic [DWIDTH-1:0] dout_o,
    output logic              rvalid_o
);

    logic [DWIDTH-1:0] dout1_q;
    logic              vld1_q;

    // First stage: capture the addressed word on a read, hold it otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout1_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            vld1_q <= rd_i;
            if (rd_i) begin
                dout1_q <= rdata_i;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DWIDTH-1:0] dout2_q;
            logic              vld2_q;

            // Second stage: forward only completed reads so dout holds between them
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    dout2_q <= '0;
                    vld2_q  <= 1'b0;
                end else begin
                    vld2_q <= vld1_q;
                    if (vld1_q) begin
                        dout2_q <= dout1_q;
                    end
                end
            end

            assign dout_o   = dout2_q;
            assign rvalid_o = vld2_q;
        end else begin : g_lat1
            assign dout_o   = dout1_q;
            assign rvalid_o = vld1_q;
        end
    endgenerate

endmodule

// File: rtl/dpbram_sc_ext.sv
// Single-clock dual-port block RAM with byte enables, selectable read latency,
// S-wins collision policy and a two-words-per-cycle clear engine.
// Port protocol: a cycle with ce=1 and we=0 is a read request that is always
// accepted (no ready); its data appears on dout together with a one-cycle
// rvalid pulse READ_LATENCY cycles later. While o_busy=1 requests are dropped.
module dpbram_sc_ext
    import dpbram_pkg::*;
#(
    parameter int                DWIDTH         = 32,
    parameter int                RAM_DEPTH      = 100000,
    parameter int                READ_LATENCY   = 1,
    parameter logic [DWIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    localparam int               AW             = addr_width(RAM_DEPTH),
    localparam int               NB             = DWIDTH / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [AW-1:0]     s_addr,
    input  logic              s_ce,
    input  logic [NB-1:0]     s_we,
    input  logic [DWIDTH-1:0] s_din,
    output logic [DWIDTH-1:0] s_dout,
    output logic              s_rvalid,
    input  logic [AW-1:0]     m_addr,
    input  logic              m_ce,
    input  logic [NB-1:0]     m_we,
    input  logic [DWIDTH-1:0] m_din,
    output logic [DWIDTH-1:0] m_dout,
    output logic              m_rvalid,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_collision,
    output clr_state_e        o_dbg_state
);

    localparam bit LATENCY_OK = read_latency_legal(READ_LATENCY);

    generate
        if (!LATENCY_OK || (DWIDTH % 8) != 0) begin : g_param_check
            $error("dpbram_sc_ext: READ_LATENCY must be 1 or 2 and DWIDTH a multiple of 8");
        end
    endgenerate

    (* ram_style = "block" *) logic [DWIDTH-1:0] mem [RAM_DEPTH];

    clr_state_e        state_q;
    logic              start_pend_q;
    logic [AW:0]       clr_addr_q;
    logic [AW:0]       clr_addr_d;
    logic              clr_last;
    logic              coll_q;
    logic              busy;

    logic              s_ce_e, m_ce_e;
    logic [NB-1:0]     s_we_e, m_we_e, m_we_mask;
    logic [AW-1:0]     s_addr_e, m_addr_e;
    logic [DWIDTH-1:0] s_din_e, m_din_e;
    logic              s_inr, m_inr, s_wr, m_wr, s_rd, m_rd, collide;
    logic [DWIDTH-1:0] s_rword, m_rword;

    assign busy       = (state_q == CLR_RUN);
    assign clr_addr_d = clr_addr_q + (AW+1)'(2);
    assign clr_last   = (clr_addr_d >= (AW+1)'(RAM_DEPTH));

    // Clear engine owns both ports while busy: S writes word k, M writes word k+1
    always_comb begin
        if (busy) begin
            s_ce_e   = 1'b1;
            s_we_e   = '1;
            s_addr_e = clr_addr_q[AW-1:0];
            s_din_e  = CLEAR_VALUE;
            m_ce_e   = 1'b1;
            m_we_e   = '1;
            m_addr_e = clr_addr_q[AW-1:0] + AW'(1);
            m_din_e  = CLEAR_VALUE;
        end else begin
            s_ce_e   = s_ce;
            s_we_e   = s_we;
            s_addr_e = s_addr;
            s_din_e  = s_din;
            m_ce_e   = m_ce;
            m_we_e   = m_we;
            m_addr_e = m_addr;
            m_din_e  = m_din;
        end
    end

    // Out-of-range accesses never touch the array; reads of them return zero
    assign s_inr     = ({1'b0, s_addr_e} < (AW+1)'(RAM_DEPTH));
    assign m_inr     = ({1'b0, m_addr_e} < (AW+1)'(RAM_DEPTH));
    assign s_wr      = s_ce_e && (s_we_e != '0) && s_inr;
    assign m_wr      = m_ce_e && (m_we_e != '0) && m_inr;
    assign s_rd      = !busy && s_ce_e && (s_we_e == '0);
    assign m_rd      = !busy && m_ce_e && (m_we_e == '0);
    assign collide   = s_wr && m_wr && (s_addr_e == m_addr_e);
    assign m_we_mask = collide ? (m_we_e & ~s_we_e) : m_we_e;
    assign s_rword   = s_inr ? mem[s_addr_e] : '0;
    assign m_rword   = m_inr ? mem[m_addr_e] : '0;

    // Byte-lane writes from both ports; lanes S owns were already removed from M
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (s_wr && s_we_e[b]) begin
                mem[s_addr_e][b*8 +: 8] <= s_din_e[b*8 +: 8];
            end
            if (m_wr && m_we_mask[b]) begin
                mem[m_addr_e][b*8 +: 8] <= m_din_e[b*8 +: 8];
            end
        end
    end

    // Clear FSM plus the registered collision pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= CLR_IDLE;
            start_pend_q <= CLEAR_ON_RESET;
            clr_addr_q   <= '0;
            coll_q       <= 1'b0;
        end else begin
            start_pend_q <= 1'b0;
            coll_q       <= collide;
            case (state_q)
                CLR_IDLE: begin
                    clr_addr_q <= '0;
                    if (start_pend_q || i_clear) begin
                        state_q <= CLR_RUN;
                    end
                end
                CLR_RUN: begin
                    if (clr_last) begin
                        state_q <= CLR_IDLE;
                    end else begin
                        clr_addr_q <= clr_addr_d;
                    end
                end
                default: state_q <= CLR_IDLE;
            endcase
        end
    end

    dpbram_port_pipe #(
        .DWIDTH       (DWIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_s_pipe (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .rd_i     (s_rd),
        .rdata_i  (s_rword),
        .dout_o   (s_dout),
        .rvalid_o (s_rvalid)
    );

    dpbram_port_pipe #(
        .DWIDTH       (DWIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_m_pipe (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .rd_i     (m_rd),
        .rdata_i  (m_rword),
        .dout_o   (m_dout),
        .rvalid_o (m_rvalid)
    );

    assign o_busy      = busy;
    assign o_collision = coll_q;
    assign o_dbg_state = state_q;

endmodule
